// File: rtl/amstrad_crtc6845_if.sv
// CPU-side bus of the CRTC: select/strobe, direction, register select and data.
interface amstrad_crtc6845_if;
  logic       ENABLE;
  logic       nCS;
  logic       R_nW;
  logic       RS;
  logic [7:0] DIN;
  logic [7:0] DOUT;

  modport master (output ENABLE, nCS, R_nW, RS, DIN, input DOUT);
  modport slave  (input ENABLE, nCS, R_nW, RS, DIN, output DOUT);
endinterface

// File: rtl/amstrad_crtc6845.sv
// UM6845R (type 1) CRTC: character-rate raster timing, sync and VRAM address
// generation for the CPC gate array.
// Optional feature: define CRTC_STATUS_EN to return {2'b00, vblank, 5'b0} on RS=0 reads.
module amstrad_crtc6845 #(
  parameter int unsigned HTOTAL_RST = 63,
  parameter int unsigned VTOTAL_RST = 38
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  CE,
  amstrad_crtc6845_if.slave     bus,
  output logic                  HSYNC,
  output logic                  VSYNC,
  output logic                  DE,
  output logic [13:0]           MA,
  output logic [4:0]            RA,
  output logic                  CURSOR
);

  localparam int unsigned MA_W     = 14;
  localparam int unsigned VS_LINES = 16;

  // programmable registers, stored at their implemented widths
  logic [4:0] ar;
  logic [7:0] r0, r1, r2;
  logic [3:0] r3;
  logic [6:0] r4, r6, r7;
  logic [4:0] r5, r9, r10, r11;
  logic [5:0] r12, r14;
  logic [7:0] r13, r15;

  // counters and timing state
  logic [7:0]      hcc;
  logic [4:0]      vlc;
  logic [6:0]      vcc;
  logic            in_adj;
  logic            hdisp_q, vdisp_q;
  logic [3:0]      hs_cnt;
  logic [4:0]      vs_cnt;
  logic [MA_W-1:0] ma_row;

  // per-tick decode of the current character position
  logic            line_end, last_raster, row_start, restart, enter_adj;
  logic            hdisp_c, vdisp_c, hs_start, hsync_c, vs_start, vsync_c, cursor_c;
  logic [4:0]      vs_nxt;
  logic [MA_W-1:0] ma_c;
  logic [7:0]      rd_data;

  // CPU writes to the address register and the data registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ar  <= '0;
      r0  <= 8'(HTOTAL_RST);
      r1  <= '0;
      r2  <= '0;
      r3  <= '0;
      r4  <= 7'(VTOTAL_RST);
      r5  <= '0;
      r6  <= '0;
      r7  <= '0;
      r9  <= '0;
      r10 <= '0;
      r11 <= '0;
      r12 <= '0;
      r13 <= '0;
      r14 <= '0;
      r15 <= '0;
    end else if (bus.ENABLE && !bus.nCS && !bus.R_nW) begin
      if (!bus.RS) begin
        ar <= bus.DIN[4:0];
      end else begin
        case (ar)
          5'd0:  r0  <= bus.DIN;
          5'd1:  r1  <= bus.DIN;
          5'd2:  r2  <= bus.DIN;
          5'd3:  r3  <= bus.DIN[3:0];
          5'd4:  r4  <= bus.DIN[6:0];
          5'd5:  r5  <= bus.DIN[4:0];
          5'd6:  r6  <= bus.DIN[6:0];
          5'd7:  r7  <= bus.DIN[6:0];
          5'd9:  r9  <= bus.DIN[4:0];
          5'd10: r10 <= bus.DIN[4:0];
          5'd11: r11 <= bus.DIN[4:0];
          5'd12: r12 <= bus.DIN[5:0];
          5'd13: r13 <= bus.DIN;
          5'd14: r14 <= bus.DIN[5:0];
          5'd15: r15 <= bus.DIN;
          default: ;
        endcase
      end
    end
  end

  // CPU read path; only the cursor address (and optional status) is visible
  always_comb begin
    rd_data = 8'h00;
    if (bus.RS) begin
      case (ar)
        5'd14:   rd_data = {2'b00, r14};
        5'd15:   rd_data = r15;
        default: rd_data = 8'h00;
      endcase
    end else begin
`ifdef CRTC_STATUS_EN
      rd_data = {2'b00, ~vdisp_q, 5'b00000};
`else
      rd_data = 8'h00;
`endif
    end
    bus.DOUT = (!bus.nCS && bus.R_nW) ? rd_data : 8'h00;
  end

  // decode of the current character: display windows, sync starts, frame events
  always_comb begin
    line_end    = (hcc == r0);
    last_raster = !in_adj && (vlc == r9);
    row_start   = !in_adj && (hcc == 8'd0) && (vlc == 5'd0);
    enter_adj   = line_end && last_raster && (vcc == r4) && (r5 != 5'd0);
    restart     = line_end && (in_adj ? (5'(vlc + 5'd1) >= r5)
                                      : (last_raster && (vcc == r4) && (r5 == 5'd0)));

    hdisp_c = hdisp_q;
    if (hcc == 8'd0) hdisp_c = 1'b1;
    if (hcc == r1)   hdisp_c = 1'b0;
    vdisp_c = (row_start && (vcc == r6)) ? 1'b0 : vdisp_q;

    hs_start = (hcc == r2) && (r3 != 4'd0);
    hsync_c  = hs_start || (hs_cnt != 4'd0);

    vs_start = row_start && (vcc == r7);
    vsync_c  = vs_start || (vs_cnt != 5'd0);
    vs_nxt   = vs_start ? 5'(VS_LINES) : vs_cnt;
    if (line_end && (vs_nxt != 5'd0)) vs_nxt = vs_nxt - 5'd1;

    ma_c     = ma_row + MA_W'(hcc);
    cursor_c = hdisp_c && vdisp_c && (ma_c == {r14, r15}) && (vlc >= r10) && (vlc <= r11);
  end

  // counters advance and outputs register once per character clock
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hcc     <= '0;
      vlc     <= '0;
      vcc     <= '0;
      in_adj  <= 1'b0;
      hdisp_q <= 1'b0;
      vdisp_q <= 1'b1;
      hs_cnt  <= '0;
      vs_cnt  <= '0;
      ma_row  <= '0;
      HSYNC   <= 1'b0;
      VSYNC   <= 1'b0;
      DE      <= 1'b0;
      MA      <= '0;
      RA      <= '0;
      CURSOR  <= 1'b0;
    end else if (CE) begin
      HSYNC  <= hsync_c;
      VSYNC  <= vsync_c;
      DE     <= hdisp_c && vdisp_c;
      MA     <= ma_c;
      RA     <= vlc;
      CURSOR <= cursor_c;

      hcc     <= line_end ? 8'd0 : hcc + 8'd1;
      hdisp_q <= hdisp_c;
      vdisp_q <= vdisp_c;
      vs_cnt  <= vs_nxt;
      if (hs_start)            hs_cnt <= r3 - 4'd1;
      else if (hs_cnt != 4'd0) hs_cnt <= hs_cnt - 4'd1;

      if (last_raster && (hcc == r1)) ma_row <= ma_row + MA_W'(r1);

      if (restart) begin
        vcc     <= '0;
        vlc     <= '0;
        in_adj  <= 1'b0;
        vdisp_q <= 1'b1;
        ma_row  <= {r12, r13};
      end else if (enter_adj) begin
        in_adj <= 1'b1;
        vlc    <= '0;
      end else if (line_end) begin
        if (last_raster) begin
          vlc <= '0;
          vcc <= vcc + 7'd1;
        end else begin
          vlc <= vlc + 5'd1;
        end
      end
    end
  end

endmodule
